// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, FSM states,
// trigger kinds, exception codes and the default exception vector base.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned ADDR_W  = 32;

  // Hold masks: a stalling stage freezes itself and everything upstream
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [CODE_W-1:0] EXC_CODE_TIMEOUT = 5'h1F;
  localparam logic [ADDR_W-1:0] EXC_BASE_DEFAULT = 32'h0000_0020;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TRIG_NONE    = 2'd0,
    TRIG_EXC     = 2'd1,
    TRIG_TIMEOUT = 2'd2,
    TRIG_ERET    = 2'd3
  } trig_e;

  function automatic logic [ADDR_W-1:0] exc_vector(input logic [ADDR_W-1:0] base,
                                                   input logic [CODE_W-1:0] code);
    return base + ADDR_W'({code, 2'b00});
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stall cycles and flags the cycle whose count reaches
// STALL_TIMEOUT-1 while a stall is still being requested.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_timeout_c
);

  localparam int unsigned CNT_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit       = (r_cnt == CNT_LAST);
  assign o_timeout_c = i_en && w_hit;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_hit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall decode, one-cycle flush/redirect
// on exception, eret or stall timeout. PIPE_CTRL_PERF_EN adds a stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned       STALL_TIMEOUT = 1023,
  parameter logic [ADDR_W-1:0] EXC_BASE      = EXC_BASE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                exc_req,
  input  logic [CODE_W-1:0]   exc_code_i,
  input  logic [ADDR_W-1:0]   exc_pc_i,
  input  logic                eret_req,
  input  logic [ADDR_W-1:0]   epc_i,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic                new_pc_valid,
  output logic [ADDR_W-1:0]   new_pc,
  output logic [CODE_W-1:0]   exc_code_o,
  output logic [ADDR_W-1:0]   epc_o,
  output logic [31:0]         stall_cycles
);

  state_e             r_state;
  state_e             w_state_nxt;
  trig_e              w_trig;
  logic [STALL_W-1:0] w_stall_raw;
  logic               w_timeout;
  logic               r_flush;
  logic [ADDR_W-1:0]  r_new_pc;
  logic [CODE_W-1:0]  r_exc_code;
  logic [ADDR_W-1:0]  r_epc;

  // Highest requesting stage wins; nothing is requested in FLUSH or reset
  always_comb begin
    w_stall_raw = STALL_NONE;
    if (!rst && r_state == ST_RUN) begin
      if (stallreq_mem)     w_stall_raw = STALL_MEM;
      else if (stallreq_ex) w_stall_raw = STALL_EX;
      else if (stallreq_id) w_stall_raw = STALL_ID;
      else if (stallreq_if) w_stall_raw = STALL_IF;
    end
  end

  // Enable uses the raw request so the timeout never loops back through stall
  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_stall_raw != STALL_NONE),
    .i_clr       (stall == STALL_NONE),
    .o_timeout_c (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_trig      = TRIG_NONE;
    stall       = STALL_NONE;
    case (r_state)
      ST_RUN: begin
        if (!rst) begin
          if (exc_req)        w_trig = TRIG_EXC;
          else if (w_timeout) w_trig = TRIG_TIMEOUT;
          else if (eret_req)  w_trig = TRIG_ERET;
        end
        if (w_trig == TRIG_NONE) stall = w_stall_raw;
        else                     w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
    endcase
  end

  // Redirect target and CP0 cause/EPC are captured in the trigger cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush    <= 1'b0;
      r_new_pc   <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_flush <= (w_state_nxt == ST_FLUSH);
      case (w_trig)
        TRIG_EXC: begin
          r_new_pc   <= exc_vector(EXC_BASE, exc_code_i);
          r_exc_code <= exc_code_i;
          r_epc      <= exc_pc_i;
        end
        TRIG_TIMEOUT: begin
          r_new_pc   <= exc_vector(EXC_BASE, EXC_CODE_TIMEOUT);
          r_exc_code <= EXC_CODE_TIMEOUT;
          r_epc      <= exc_pc_i;
        end
        TRIG_ERET: r_new_pc <= epc_i;
        default: ;
      endcase
    end
  end

  assign flush        = r_flush;
  assign new_pc_valid = r_flush;
  assign new_pc       = r_new_pc;
  assign exc_code_o   = r_exc_code;
  assign epc_o        = r_epc;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall[0] && r_stall_cycles != 32'hFFFF_FFFF) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, timeout and
// watchdog-clear sequences, then randomized traffic against a reference model.
module tb_pipe_ctrl;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] BASE = 32'h0000_0020;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        exc_req = 1'b0, eret_req = 1'b0;
  logic [4:0]  exc_code_i = '0;
  logic [31:0] exc_pc_i = '0, epc_i = '0;
  logic [5:0]  stall;
  logic        flush, new_pc_valid;
  logic [31:0] new_pc, epc_o, stall_cycles;
  logic [4:0]  exc_code_o;

  pipe_ctrl #(.STALL_TIMEOUT(TO), .EXC_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_req(exc_req), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .eret_req(eret_req), .epc_i(epc_i),
    .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid), .new_pc(new_pc),
    .exc_code_o(exc_code_o), .epc_o(epc_o), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (values visible on registered outputs)
  bit          m_flush = 1'b0;
  int          m_wd = 0;
  logic [31:0] m_pc = '0, m_epc = '0, m_perf = '0;
  logic [4:0]  m_code = '0;
  logic [5:0]  m_exp_stall = '0;
  int          m_kind = 0;   // 0 none, 1 exception, 2 timeout, 3 eret

  typedef struct {
    logic        rst;
    logic [3:0]  req;        // {mem, ex, id, if}
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        eret;
    logic [31:0] epc;
    logic        chk;
    logic [5:0]  x_stall;
    logic        x_flush;
    logic [31:0] x_pc;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic [31:0] x_perf;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    logic [5:0] raw;
    raw = 6'd0;
    m_kind = 0;
    m_exp_stall = 6'd0;
    if (!rst && !m_flush) begin
      if (stallreq_mem)     raw = 6'b011111;
      else if (stallreq_ex) raw = 6'b001111;
      else if (stallreq_id) raw = 6'b000111;
      else if (stallreq_if) raw = 6'b000011;
      if (exc_req)                         m_kind = 1;
      else if (raw != 0 && m_wd == TO - 1) m_kind = 2;
      else if (eret_req)                   m_kind = 3;
      m_exp_stall = (m_kind == 0) ? raw : 6'd0;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_flush = 1'b0; m_wd = 0; m_pc = '0; m_code = '0; m_epc = '0; m_perf = '0;
    end else if (m_flush) begin
      m_flush = 1'b0;
      m_wd = 0;
    end else begin
      case (m_kind)
        1: begin m_pc = BASE + 32'(exc_code_i) * 4; m_code = exc_code_i; m_epc = exc_pc_i; end
        2: begin m_pc = BASE + 32'h1F * 4; m_code = 5'h1F; m_epc = exc_pc_i; end
        3: m_pc = epc_i;
        default: ;
      endcase
      m_flush = (m_kind != 0);
      m_wd = (m_exp_stall != 0) ? m_wd + 1 : 0;
      if (PERF && m_exp_stall[0] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic e, input logic [4:0] c,
                       input logic [31:0] pc, input logic er, input logic [31:0] ep);
    @(negedge clk);
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    exc_req = e; exc_code_i = c; exc_pc_i = pc; eret_req = er; epc_i = ep;
    #1;
    model_eval();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".stall"}, 32'(stall), 32'(m_exp_stall));
    check({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check({tag, ".npv"}, 32'(new_pc_valid), 32'(m_flush));
    check({tag, ".new_pc"}, new_pc, m_pc);
    check({tag, ".code"}, 32'(exc_code_o), 32'(m_code));
    check({tag, ".epc"}, epc_o, m_epc);
    check({tag, ".perf"}, stall_cycles, m_perf);
  endtask

  initial begin
    //          rst  req      exc  code   pc         eret epc        chk  stall  fl   new_pc     code   epc        perf
    tbl[0]  = '{1'b1, 4'b1010, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b0, 6'h00, 1'b0, 32'h00,  5'h00, 32'h000, 32'd0};
    tbl[1]  = '{1'b1, 4'b1010, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h00,  5'h00, 32'h000, 32'd0};
    tbl[2]  = '{1'b0, 4'b1010, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h1F, 1'b0, 32'h00,  5'h00, 32'h000, 32'd0};
    tbl[3]  = '{1'b0, 4'b0010, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h07, 1'b0, 32'h00,  5'h00, 32'h000, 32'd1};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h03, 1'b0, 32'h00,  5'h00, 32'h000, 32'd2};
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h0F, 1'b0, 32'h00,  5'h00, 32'h000, 32'd3};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h00,  5'h00, 32'h000, 32'd4};
    tbl[7]  = '{1'b0, 4'b0100, 1'b1, 5'h0C, 32'h100, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h00,  5'h00, 32'h000, 32'd4};
    tbl[8]  = '{1'b0, 4'b1000, 1'b1, 5'h03, 32'h999, 1'b1, 32'h777, 1'b1, 6'h00, 1'b1, 32'h50,  5'h0C, 32'h100, 32'd4};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h50,  5'h0C, 32'h100, 32'd4};
    tbl[10] = '{1'b0, 4'b0010, 1'b0, 5'h00, 32'h000, 1'b1, 32'h200, 1'b1, 6'h00, 1'b0, 32'h50,  5'h0C, 32'h100, 32'd4};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b1, 32'h200, 5'h0C, 32'h100, 32'd4};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 5'h04, 32'h300, 1'b1, 32'h400, 1'b1, 6'h00, 1'b0, 32'h200, 5'h0C, 32'h100, 32'd4};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b1, 32'h30,  5'h04, 32'h300, 32'd4};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h30,  5'h04, 32'h300, 32'd4};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b1, 32'h500, 1'b1, 6'h00, 1'b0, 32'h30,  5'h04, 32'h300, 32'd4};
    tbl[16] = '{1'b1, 4'b1000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b1, 32'h500, 5'h04, 32'h300, 32'd4};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 5'h00, 32'h000, 1'b0, 32'h000, 1'b1, 6'h00, 1'b0, 32'h00,  5'h00, 32'h000, 32'd0};

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].exc, tbl[i].code, tbl[i].pc, tbl[i].eret, tbl[i].epc);
      check($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].x_stall));
      if (tbl[i].chk) begin
        check($sformatf("vec%0d.flush", i), 32'(flush), 32'(tbl[i].x_flush));
        check($sformatf("vec%0d.npv", i), 32'(new_pc_valid), 32'(tbl[i].x_flush));
        check($sformatf("vec%0d.new_pc", i), new_pc, tbl[i].x_pc);
        check($sformatf("vec%0d.code", i), 32'(exc_code_o), 32'(tbl[i].x_code));
        check($sformatf("vec%0d.epc", i), epc_o, tbl[i].x_epc);
        check($sformatf("vec%0d.perf", i), stall_cycles, PERF ? tbl[i].x_perf : 32'd0);
      end
      model_commit();
    end

    // Held ex stall: seven stalled cycles, timeout trigger on the eighth
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 4'b0100, 1'b0, 5'h00, 32'h0ABC, 1'b0, 32'h0);
      check($sformatf("tmo%0d.stall", k), 32'(stall), 32'h0F);
      check($sformatf("tmo%0d.flush", k), 32'(flush), 32'h0);
      model_commit();
    end
    drive(1'b0, 4'b0100, 1'b0, 5'h00, 32'h0ABC, 1'b0, 32'h0);
    check("tmo8.stall", 32'(stall), 32'h00);
    model_commit();
    drive(1'b0, 4'b0100, 1'b0, 5'h00, 32'h0ABC, 1'b0, 32'h0);
    check("tmo9.stall", 32'(stall), 32'h00);
    check("tmo9.flush", 32'(flush), 32'h1);
    check("tmo9.npv", 32'(new_pc_valid), 32'h1);
    check("tmo9.code", 32'(exc_code_o), 32'h1F);
    check("tmo9.epc", epc_o, 32'h0ABC);
    check("tmo9.new_pc", new_pc, 32'h9C);
    model_commit();
    drive(1'b0, 4'b0100, 1'b0, 5'h00, 32'h0ABC, 1'b0, 32'h0);
    check("tmo10.stall", 32'(stall), 32'h0F);
    check("tmo10.flush", 32'(flush), 32'h0);
    model_commit();

    // A single idle cycle restarts the watchdog: two runs of seven never time out
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0);
      model_commit();
      for (int k = 1; k <= 7; k++) begin
        drive(1'b0, 4'b0100, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0);
        check($sformatf("wdclr%0d_%0d.stall", r, k), 32'(stall), 32'h0F);
        check($sformatf("wdclr%0d_%0d.flush", r, k), 32'(flush), 32'h0);
        model_commit();
      end
    end
    drive(1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0);
    check("wdclr_end.flush", 32'(flush), 32'h0);
    model_commit();

    // Randomized traffic against the reference model
    drive(1'b1, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0);
    model_commit();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(63) == 0), 4'($urandom), ($urandom_range(15) == 0), 5'($urandom),
            $urandom, ($urandom_range(11) == 0), $urandom);
      check_model($sformatf("rnd%0d", c));
      model_commit();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 1023, meaning the maximum consecutive stall cycles before a timeout exception is raised.
REQ-002 SHALL have parameter EXC_BASE, default 32'h0000_0020, meaning the exception vector base address.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port stallreq_if  in  1  fetch-wait stall request.
REQ-006 SHALL have port stallreq_id  in  1  load-use stall request.
REQ-007 SHALL have port stallreq_ex  in  1  multicycle mult/div stall request.
REQ-008 SHALL have port stallreq_mem  in  1  data-bus-wait stall request.
REQ-009 SHALL have port exc_req  in  1  exception request from MEM.
REQ-010 SHALL have port exc_code_i  in  5  exception cause code.
REQ-011 SHALL have port exc_pc_i  in  32  PC of the faulting instruction.
REQ-012 SHALL have port eret_req  in  1  return-from-exception request.
REQ-013 SHALL have port epc_i  in  32  saved return address from CP0.
REQ-014 SHALL have port stall  out  6  per-stage hold: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb.
REQ-015 SHALL have port flush  out  1  clears all pipeline registers.
REQ-016 SHALL have port new_pc_valid  out  1  PC redirect strobe.
REQ-017 SHALL have port new_pc  out  32  redirect target.
REQ-018 SHALL have port exc_code_o  out  5  latched cause code for CP0.
REQ-019 SHALL have port epc_o  out  32  latched faulting PC for CP0.
REQ-020 SHALL have port stall_cycles  out  32  performance counter (see Configuration).

Function
REQ-021 SHALL decode stall combinationally in state RUN, with the highest requesting stage dominating: mem gives 011111, else ex gives 001111, else id gives 000111, else if gives 000011, else 000000.
REQ-022 SHALL use FSM states RUN and FLUSH; RUN -> FLUSH when exc_req, eret_req or a watchdog timeout is seen in RUN; FLUSH -> RUN unconditionally after one cycle.
REQ-023 SHALL, on a trigger in cycle N, drive in cycle N+1 (FLUSH): flush=1, new_pc_valid=1, stall=000000.
REQ-024 SHALL set new_pc=EXC_BASE+{exc_code,2'b00} for exceptions and new_pc=epc_i (sampled at N) for eret.
REQ-025 SHALL resolve same-cycle triggers with priority exc_req > timeout > eret_req; the losers are dropped.
REQ-026 SHALL override stalls with triggers: stall=000000 in cycle N when a trigger is present.
REQ-027 SHALL ignore exc_req, eret_req and stall requests while in FLUSH: stall=000000 and nothing is queued.
REQ-028 SHALL latch exc_code_o and epc_o at cycle N for exceptions only; eret leaves them unchanged; timeout latches code 5'h1F with epc_o=exc_pc_i.
REQ-029 SHALL run a watchdog counter that increments each cycle stall!=0 and clears when stall==0 or in FLUSH.
REQ-030 SHALL raise a timeout trigger when the watchdog count equals STALL_TIMEOUT-1 while stall!=0.
REQ-031 SHALL hold flush and new_pc_valid at 0 in RUN.

Reset
REQ-032 SHALL, on rst, set state=RUN, flush=0, new_pc_valid=0, new_pc=0, exc_code_o=0, epc_o=0, watchdog=0 and stall_cycles=0; stall=000000 during reset.
REQ-033 SHALL, on rst asserted in FLUSH, abort the redirect and return to RUN with no pending trigger.

Configuration
REQ-034 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cycles on every cycle with stall[0]=1, saturating at 32'hFFFF_FFFF.
REQ-035 SHALL, with PIPE_CTRL_PERF_EN undefined, tie stall_cycles to 0 and build no counter logic; the port is present in both builds.

Structure
REQ-036 SHALL place stall vector encodings, FSM state encodings, exception codes (including 5'h1F timeout) and EXC_BASE in the shared defines file.
REQ-037 SHALL implement the watchdog as sub-module stall_watchdog (inputs: count enable and clear; output: timeout pulse).

Verification
REQ-038 SHALL verify: stallreq_id=1 and stallreq_mem=1 together -> stall=011111; stallreq_id alone -> stall=000111.
REQ-039 SHALL verify: exc_req=1, exc_code_i=5'h0C, exc_pc_i=32'h100 at N -> at N+1 flush=1, new_pc=32'h50, epc_o=32'h100; at N+2 flush=0.
REQ-040 SHALL verify: eret_req=1, epc_i=32'h200 -> next cycle new_pc=32'h200, exc_code_o unchanged.
REQ-041 SHALL verify: exc_req and eret_req in the same cycle -> exception vector taken; exc_req in FLUSH -> ignored.
REQ-042 SHALL verify: STALL_TIMEOUT=8 with stallreq_ex held -> after 8 stall cycles flush=1 and exc_code_o=5'h1F.
REQ-043 SHALL verify: rst during FLUSH -> next cycle flush=0, and stall_cycles=0 (PERF build) or 0 always (non-PERF).
